// File: rtl/btb_pkg.sv
// Shared width helpers and PC field extraction for the branch target buffer.
package btb_pkg;

    function automatic int idx_w(input int sets_log2);
        return sets_log2;
    endfunction

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Returned wide; callers cast down to their configured field width.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int sets_log2);
        return (pc >> 2) & ((64'd1 << sets_log2) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int sets_log2,
                                           input int tag_w);
        return (pc >> (sets_log2 + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the way to allocate on a taken miss: lowest invalid way, else round-robin.
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid,
    input  logic [WAY_W-1:0] ptr,
    output logic [WAY_W-1:0] victim,
    output logic [WAY_W-1:0] next_ptr
);

    // Pointer only advances when a valid entry is actually evicted.
    always_comb begin
        victim   = ptr;
        next_ptr = (WAYS == 1) ? '0 : ptr + WAY_W'(1);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim   = WAY_W'(w);
                next_ptr = ptr;
            end
        end
    end

endmodule

// File: rtl/btb_table.sv
// Set-associative branch target buffer: registered lookup, EX-driven update,
// post-reset clear sweep and per-set round-robin replacement.
module btb_table
    import btb_pkg::*;
#(
    parameter int SETS_LOG2 = 8,
    parameter int WAYS      = 2,
    parameter int TAG_W     = 8,
    parameter int PC_W      = 32,
    localparam int IDX_W    = idx_w(SETS_LOG2),
    localparam int WAY_W    = way_w(WAYS),
    localparam int SETS     = 1 << SETS_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             init_busy,
    input  logic             req_valid,
    input  logic [PC_W-1:0]  req_pc,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [WAY_W-1:0] resp_way,
    output logic [PC_W-1:0]  resp_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
    } btb_entry_t;

    btb_entry_t       mem [SETS][WAYS];
    logic [WAY_W-1:0] rr_ptr [SETS];
    logic [IDX_W-1:0] sweep_cnt;

    logic [IDX_W-1:0] req_idx, upd_idx;
    logic [TAG_W-1:0] req_tag, upd_tag;

    assign req_idx = IDX_W'(pc_index(64'(req_pc), SETS_LOG2));
    assign upd_idx = IDX_W'(pc_index(64'(upd_pc), SETS_LOG2));
    assign req_tag = TAG_W'(pc_tag(64'(req_pc), SETS_LOG2, TAG_W));
    assign upd_tag = TAG_W'(pc_tag(64'(upd_pc), SETS_LOG2, TAG_W));

    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic [PC_W-1:0]  lk_target;

    // Contents are stale until the sweep finishes, so lookups miss while busy.
    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        lk_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!init_busy && mem[req_idx][w].valid && mem[req_idx][w].tag == req_tag) begin
                lk_hit    = 1'b1;
                lk_way    = WAY_W'(w);
                lk_target = mem[req_idx][w].target;
            end
        end
    end

    logic             up_hit;
    logic [WAY_W-1:0] up_way;
    logic [WAYS-1:0]  up_set_valid;

    always_comb begin
        up_hit       = 1'b0;
        up_way       = '0;
        up_set_valid = '0;
        for (int w = 0; w < WAYS; w++) begin
            up_set_valid[w] = mem[upd_idx][w].valid;
            if (mem[upd_idx][w].valid && mem[upd_idx][w].tag == upd_tag) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
    end

    logic [WAY_W-1:0] victim, next_ptr;

    btb_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .valid    (up_set_valid),
        .ptr      (rr_ptr[upd_idx]),
        .victim   (victim),
        .next_ptr (next_ptr)
    );

    logic upd_apply;
    assign upd_apply = upd_valid && !init_busy && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt <= '0;
            init_busy <= 1'b1;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (init_busy) begin
            sweep_cnt <= sweep_cnt + IDX_W'(1);
            if (sweep_cnt == IDX_W'(SETS - 1)) init_busy <= 1'b0;
        end else if (upd_apply && upd_taken && !up_hit) begin
            rr_ptr[upd_idx] <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && init_busy) begin
            for (int w = 0; w < WAYS; w++) mem[sweep_cnt][w].valid <= 1'b0;
        end else if (upd_apply) begin
            if (upd_taken) begin
                if (up_hit) begin
                    mem[upd_idx][up_way].target <= upd_target;
                end else begin
                    mem[upd_idx][victim].valid  <= 1'b1;
                    mem[upd_idx][victim].tag    <= upd_tag;
                    mem[upd_idx][victim].target <= upd_target;
                end
            end else if (up_hit) begin
                mem[upd_idx][up_way].valid <= 1'b0;
            end
        end
    end

    // Non-request cycles leave hit/way/target holding the last response.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_way    <= '0;
            resp_target <= '0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                resp_hit    <= lk_hit;
                resp_way    <= lk_way;
                resp_target <= lk_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_table.sv
// Self-checking bench for btb_table (16 sets, 2 ways, 8-bit tag).
module tb_btb_table;

    localparam int SETS = 16;
    localparam int WAYS = 2;

    logic        clk;
    logic        rst;
    logic        init_busy;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_hit;
    logic [0:0]  resp_way;
    logic [31:0] resp_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    btb_table #(.SETS_LOG2(4), .WAYS(2), .TAG_W(8), .PC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .init_busy   (init_busy),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .resp_valid  (resp_valid),
        .resp_hit    (resp_hit),
        .resp_way    (resp_way),
        .resp_target (resp_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-set list of entries, filled and evicted by the rules directly.
    logic        m_valid [SETS][WAYS];
    logic [7:0]  m_tag   [SETS][WAYS];
    logic [31:0] m_tgt   [SETS][WAYS];
    int          m_ptr   [SETS];
    int          busy_left = 0;
    logic        e_valid = 0, e_hit = 0, e_way = 0, was_rst = 0;
    logic [31:0] e_tgt = 0;

    function automatic int f_idx(input logic [31:0] pc);
        return int'((pc / 4) % SETS);
    endfunction

    function automatic logic [7:0] f_tag(input logic [31:0] pc);
        return 8'((pc / 64) % 256);
    endfunction

    task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utg);
        int s, hw, v;
        was_rst = r;
        if (r) begin
            busy_left = SETS;
            for (int i = 0; i < SETS; i++) begin
                m_ptr[i] = 0;
                for (int w = 0; w < WAYS; w++) m_valid[i][w] = 0;
            end
            e_valid = 0; e_hit = 0; e_way = 0; e_tgt = 0;
            return;
        end
        if (rv) begin
            e_valid = 1; e_hit = 0; e_way = 0; e_tgt = 0;
            s = f_idx(rpc);
            if (busy_left == 0)
                for (int w = 0; w < WAYS; w++)
                    if (m_valid[s][w] && m_tag[s][w] == f_tag(rpc)) begin
                        e_hit = 1; e_way = w[0]; e_tgt = m_tgt[s][w];
                    end
        end else begin
            e_valid = 0;
        end
        if (uv && busy_left == 0) begin
            s = f_idx(upc);
            hw = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_tag[s][w] == f_tag(upc)) hw = w;
            if (ut && hw >= 0) begin
                m_tgt[s][hw] = utg;
            end else if (ut) begin
                v = -1;
                for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
                if (v < 0) begin
                    v = m_ptr[s];
                    m_ptr[s] = (m_ptr[s] + 1) % WAYS;
                end
                m_valid[s][v] = 1; m_tag[s][v] = f_tag(upc); m_tgt[s][v] = utg;
            end else if (hw >= 0) begin
                m_valid[s][hw] = 0;
            end
        end
        if (busy_left > 0) busy_left--;
    endtask

    task automatic tick(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg);
        rst = r; req_valid = rv; req_pc = rpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg;
        @(posedge clk);
        model_step(r, rv, rpc, uv, upc, ut, utg);
        #1;
        chk("init_busy", 32'(init_busy), 32'(busy_left > 0));
        chk("resp_valid", 32'(resp_valid), 32'(e_valid));
        chk("resp_hit", 32'(resp_hit), 32'(e_hit));
        chk("resp_target", resp_target, e_tgt);
        if (e_hit || was_rst) chk("resp_way", 32'(resp_way), 32'(e_way));
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        tick(0, 1, pc, 0, 0, 0, 0);
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        tick(0, 0, 0, 1, pc, t, tg);
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic        ev;
        logic        eh;
        logic        ew;
        logic [31:0] et;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] pc, pc2, r;

        // Reset sweep length, with an update dropped during the sweep.
        tick(1, 0, 0, 0, 0, 0, 0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        n = 0;
        while (init_busy && n < 100) begin
            if (n == 0) update(32'h80000010, 1, 32'h80000100);
            else idle();
            n++;
        end
        chk("sweep_len", 32'(n), 32'd16);
        lookup(32'h80000010);
        chk("busy_upd_dropped", 32'(resp_hit), 32'd0);

        // Directed vectors: allocate/hit, invalidate, conflict, same-cycle, overwrite.
        tbl.push_back('{0, 0, 1, 32'h80000010, 1, 32'h80000100, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h80000010, 0, 0, 0, 0, 1, 1, 0, 32'h80000100});
        tbl.push_back('{0, 0, 1, 32'h80000010, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h80000010, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 32'h00000010, 1, 32'h000000A0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 32'h00000050, 1, 32'h000000B0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 32'h00000090, 1, 32'h000000C0, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h00000010, 0, 0, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 32'h00000050, 0, 0, 0, 0, 1, 1, 1, 32'h000000B0});
        tbl.push_back('{1, 32'h00000090, 0, 0, 0, 0, 1, 1, 0, 32'h000000C0});
        tbl.push_back('{1, 32'h00000020, 1, 32'h00000020, 1, 32'h00001234, 1, 0, 0, 0});
        tbl.push_back('{1, 32'h00000020, 0, 0, 0, 0, 1, 1, 0, 32'h00001234});
        tbl.push_back('{0, 0, 1, 32'h00000050, 1, 32'h000000D0, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h00000050, 0, 0, 0, 0, 1, 1, 1, 32'h000000D0});
        tbl.push_back('{0, 0, 1, 32'h00000013, 1, 32'h000000E0, 0, 0, 0, 0});
        tbl.push_back('{1, 32'h00000010, 0, 0, 0, 0, 1, 1, 1, 32'h000000E0});
        tbl.push_back('{1, 32'h00000050, 0, 0, 0, 0, 1, 0, 0, 0});
        foreach (tbl[i]) begin
            tick(0, tbl[i].rv, tbl[i].rpc, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utg);
            chk($sformatf("vec%0d_valid", i), 32'(resp_valid), 32'(tbl[i].ev));
            if (tbl[i].rv) begin
                chk($sformatf("vec%0d_hit", i), 32'(resp_hit), 32'(tbl[i].eh));
                chk($sformatf("vec%0d_target", i), resp_target, tbl[i].et);
                if (tbl[i].eh) chk($sformatf("vec%0d_way", i), 32'(resp_way), 32'(tbl[i].ew));
            end
        end

        // Reset mid-operation, then re-reset partway through the sweep.
        update(32'h00000104, 1, 32'h11111111);
        update(32'h00000208, 1, 32'h22222222);
        update(32'h0000030C, 1, 32'h33333333);
        update(32'h00000414, 1, 32'h44444444);
        lookup(32'h00000104);
        chk("pre_rst_hit", 32'(resp_hit), 32'd1);
        tick(1, 1, 32'h00000104, 0, 0, 0, 0);
        chk("rst_zero_hit", 32'(resp_hit), 32'd0);
        chk("rst_zero_target", resp_target, 32'd0);
        for (int i = 0; i < 7; i++) idle();
        tick(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (init_busy && n < 100) begin
            idle();
            n++;
        end
        chk("resweep_len", 32'(n), 32'd16);
        lookup(32'h00000104); chk("post_rst_miss0", 32'(resp_hit), 32'd0);
        lookup(32'h00000208); chk("post_rst_miss1", 32'(resp_hit), 32'd0);
        lookup(32'h0000030C); chk("post_rst_miss2", 32'(resp_hit), 32'd0);
        lookup(32'h00000414); chk("post_rst_miss3", 32'(resp_hit), 32'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            r   = $urandom();
            pc  = (r & 32'hFFFFC000) | (32'($urandom_range(0, 2)) << 6)
                | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            r   = $urandom();
            pc2 = (r & 32'hFFFFC000) | (32'($urandom_range(0, 2)) << 6)
                | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            tick(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)), pc,
                 1'($urandom_range(0, 1)), pc2, ($urandom_range(0, 3) != 0), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
